// File: rtl/w_mem_dbuf_pkg.sv
// Shared types and layer indices for the double-buffered GAN weight store.
package w_mem_dbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    localparam int L_G2     = 0;
    localparam int L_G3     = 1;
    localparam int L_D2     = 2;
    localparam int L_D3     = 3;
    localparam int N_LAYERS = 4;

endpackage

// File: rtl/w_mem_dbuf_layer_bank.sv
// One layer's active/shadow weight bank pair: shadow write port, toggle-on-commit
// active bit, and a registered-only output mux.
module w_layer_bank #(
    parameter int WIDTH = 32,
    parameter int NW    = 6,
    parameter int IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [WIDTH-1:0]    data,
    input  logic                toggle,
    output logic                active,
    output logic [NW*WIDTH-1:0] wout
);

    logic [NW-1:0][WIDTH-1:0] bank0_q, bank0_d;
    logic [NW-1:0][WIDTH-1:0] bank1_q, bank1_d;
    logic                     active_q, active_d;

    always_comb begin
        bank0_d  = bank0_q;
        bank1_d  = bank1_q;
        active_d = active_q ^ toggle;
        // Writes always land in the bank that is not currently driving the bus.
        for (int e = 0; e < NW; e++) begin
            if (we && (idx == IDX_W'(e))) begin
                if (active_q) bank0_d[e] = data;
                else          bank1_d[e] = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank0_q  <= '0;
            bank1_q  <= '0;
            active_q <= 1'b0;
        end else begin
            bank0_q  <= bank0_d;
            bank1_q  <= bank1_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign wout   = active_q ? bank1_q : bank0_q;

endmodule

// File: rtl/w_mem_dbuf.sv
// Loadable double-buffered weight store: word-serial shadow load, per-layer atomic
// bank swap on commit. Top holds the load FSM, word counter and layer decode.
module w_mem_dbuf
    import w_mem_dbuf_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_INPUT = 2,
    parameter int N_G_L2  = 3,
    parameter int N_G_L3  = 9,
    parameter int N_D_L2  = 3,
    parameter int N_D_L3  = 1,
    localparam int NW_G2  = N_INPUT * N_G_L2,
    localparam int NW_G3  = N_G_L2 * N_G_L3,
    localparam int NW_D2  = N_G_L3 * N_D_L2,
    localparam int NW_D3  = N_D_L2 * N_D_L3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   load_last,
    input  logic                   commit,
    input  logic [3:0]             commit_mask,
    output logic [NW_G2*WIDTH-1:0] wg2,
    output logic [NW_G3*WIDTH-1:0] wg3,
    output logic [NW_D2*WIDTH-1:0] wd2,
    output logic [NW_D3*WIDTH-1:0] wd3,
    output logic [3:0]             active_sel,
    output logic                   shadow_full,
    output logic                   load_err,
    output logic                   commit_rej
);

    localparam int N_TOT  = NW_G2 + NW_G3 + NW_D2 + NW_D3;
    localparam int CNT_W  = (N_TOT > 1) ? $clog2(N_TOT) : 1;
    localparam int OFF_G3 = NW_G2;
    localparam int OFF_D2 = OFF_G3 + NW_G3;
    localparam int OFF_D3 = OFF_D2 + NW_D2;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            load_err_q, load_err_d;
    logic                            commit_rej_q, commit_rej_d;
    logic                            accept, is_last;
    logic [N_LAYERS-1:0]             we, toggle, act;
    logic [N_LAYERS-1:0][CNT_W-1:0]  lidx;

    assign load_ready = (state_q != ST_FULL);
    assign accept     = load_valid & load_ready;
    assign is_last    = (cnt_q == CNT_W'(N_TOT - 1));

    // Word index -> (layer, element) over the contiguous g2,g3,d2,d3 stream.
    always_comb begin
        we         = '0;
        lidx[L_G2] = cnt_q;
        lidx[L_G3] = cnt_q - CNT_W'(OFF_G3);
        lidx[L_D2] = cnt_q - CNT_W'(OFF_D2);
        lidx[L_D3] = cnt_q - CNT_W'(OFF_D3);
        if (accept) begin
            if      (cnt_q < CNT_W'(OFF_G3)) we[L_G2] = 1'b1;
            else if (cnt_q < CNT_W'(OFF_D2)) we[L_G3] = 1'b1;
            else if (cnt_q < CNT_W'(OFF_D3)) we[L_D2] = 1'b1;
            else                             we[L_D3] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_err_d   = 1'b0;
        commit_rej_d = 1'b0;
        toggle       = '0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (load_last != is_last) begin
                        load_err_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else if (is_last) begin
                        cnt_d   = '0;
                        state_d = ST_FULL;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                if (commit) commit_rej_d = 1'b1;
            end
            ST_FULL: begin
                if (commit) begin
                    toggle  = commit_mask;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            load_err_q   <= 1'b0;
            commit_rej_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_err_q   <= load_err_d;
            commit_rej_q <= commit_rej_d;
        end
    end

    assign shadow_full = (state_q == ST_FULL);
    assign load_err    = load_err_q;
    assign commit_rej  = commit_rej_q;
    assign active_sel  = act;

    w_layer_bank #(.WIDTH(WIDTH), .NW(NW_G2), .IDX_W(CNT_W)) u_g2 (
        .clk(clk), .rst(rst), .we(we[L_G2]), .idx(lidx[L_G2]), .data(load_data),
        .toggle(toggle[L_G2]), .active(act[L_G2]), .wout(wg2)
    );
    w_layer_bank #(.WIDTH(WIDTH), .NW(NW_G3), .IDX_W(CNT_W)) u_g3 (
        .clk(clk), .rst(rst), .we(we[L_G3]), .idx(lidx[L_G3]), .data(load_data),
        .toggle(toggle[L_G3]), .active(act[L_G3]), .wout(wg3)
    );
    w_layer_bank #(.WIDTH(WIDTH), .NW(NW_D2), .IDX_W(CNT_W)) u_d2 (
        .clk(clk), .rst(rst), .we(we[L_D2]), .idx(lidx[L_D2]), .data(load_data),
        .toggle(toggle[L_D2]), .active(act[L_D2]), .wout(wd2)
    );
    w_layer_bank #(.WIDTH(WIDTH), .NW(NW_D3), .IDX_W(CNT_W)) u_d3 (
        .clk(clk), .rst(rst), .we(we[L_D3]), .idx(lidx[L_D3]), .data(load_data),
        .toggle(toggle[L_D3]), .active(act[L_D3]), .wout(wd3)
    );

endmodule

// File: tb/tb_w_mem_dbuf.sv
// Directed bench for w_mem_dbuf: load/commit flow, partial swaps, error pulses, reset abort.
module tb_w_mem_dbuf;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid, load_ready, load_last;
    logic [31:0]   load_data;
    logic          commit;
    logic [3:0]    commit_mask;
    logic [191:0]  wg2;
    logic [863:0]  wg3;
    logic [863:0]  wd2;
    logic [95:0]   wd3;
    logic [3:0]    active_sel;
    logic          shadow_full, load_err, commit_rej;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    w_mem_dbuf dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .commit(commit),
        .commit_mask(commit_mask), .wg2(wg2), .wg3(wg3), .wd2(wd2), .wd3(wd3),
        .active_sel(active_sel), .shadow_full(shadow_full), .load_err(load_err),
        .commit_rej(commit_rej)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Stream n words (data=base+k), load_last at last_at, optional commit on the final word.
    task automatic stream(input int n, input logic [31:0] base, input int last_at, input logic cmt_last);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = base + 32'(k);
            load_last  = (k == last_at);
            commit     = cmt_last && (k == n - 1);
            commit_mask = 4'hF;
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        commit     = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] mask);
        @(negedge clk);
        commit      = 1'b1;
        commit_mask = mask;
        @(negedge clk);
        commit      = 1'b0;
        commit_mask = 4'h0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        commit = 1'b0; commit_mask = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        chk("rst_wg2", wg2[31:0], 32'd0);
        chk("rst_wd3", wd3[95:64], 32'd0);
        chk("rst_active", {28'd0, active_sel}, 32'h0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_full", {31'd0, shadow_full}, 32'd0);

        // 2: full load, commit coincident with last word is rejected
        stream(63, 32'd1, 62, 1'b1);
        chk("t2_full", {31'd0, shadow_full}, 32'd1);
        chk("t2_ready", {31'd0, load_ready}, 32'd0);
        chk("t2_rej_on_last", {31'd0, commit_rej}, 32'd1);
        chk("t2_bus_hold", wg2[31:0], 32'd0);
        do_commit(4'hF);
        chk("t2_wg2", wg2[31:0], 32'd1);
        chk("t2_wg3", wg3[31:0], 32'd7);
        chk("t2_wd2", wd2[31:0], 32'd34);
        chk("t2_wd3", wd3[95:64], 32'd63);
        chk("t2_wg3_last", wg3[863:832], 32'd33);
        chk("t2_active", {28'd0, active_sel}, 32'hF);
        chk("t2_idle", {31'd0, load_ready}, 32'd1);

        // 3: partial swap of g2 and d2 only
        stream(63, 32'd100, 62, 1'b0);
        do_commit(4'b0101);
        chk("t3_wg2", wg2[31:0], 32'd100);
        chk("t3_wd2", wd2[31:0], 32'd133);
        chk("t3_wg3", wg3[31:0], 32'd7);
        chk("t3_wd3", wd3[95:64], 32'd63);
        chk("t3_active", {28'd0, active_sel}, 32'hA);

        // 4: early load_last -> error, then commit rejected
        stream(11, 32'd500, 10, 1'b0);
        chk("t4_err", {31'd0, load_err}, 32'd1);
        chk("t4_ready", {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, load_err}, 32'd0);
        do_commit(4'hF);
        chk("t4_rej", {31'd0, commit_rej}, 32'd1);
        chk("t4_active", {28'd0, active_sel}, 32'hA);
        chk("t4_wg2", wg2[31:0], 32'd100);

        // 5: valid held while FULL is ignored; commit afterwards swaps correctly
        stream(63, 32'd200, 62, 1'b0);
        load_valid = 1'b1; load_data = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_ready", {31'd0, load_ready}, 32'd0);
        end
        load_valid = 1'b0;
        chk("t5_full", {31'd0, shadow_full}, 32'd1);
        do_commit(4'hF);
        chk("t5_active", {28'd0, active_sel}, 32'h5);
        chk("t5_wg2", wg2[31:0], 32'd200);
        chk("t5_wg3", wg3[31:0], 32'd206);
        chk("t5_wd2", wd2[31:0], 32'd233);
        chk("t5_wd3", wd3[95:64], 32'd262);
        // counter restarted at 0: a 1-word burst with last is misplaced
        stream(1, 32'd1, 0, 1'b0);
        chk("t5_cnt0", {31'd0, load_err}, 32'd1);

        // 6: reset mid-load, then full load
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            load_valid = 1'b1; load_data = 32'd999; load_last = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; load_valid = 1'b0;
        chk("t6_rst_active", {28'd0, active_sel}, 32'h0);
        chk("t6_rst_wg2", wg2[31:0], 32'd0);
        chk("t6_rst_ready", {31'd0, load_ready}, 32'd1);
        stream(63, 32'd1, 62, 1'b0);
        do_commit(4'hF);
        chk("t6_wg2", wg2[31:0], 32'd1);
        chk("t6_wg2_hi", wg2[191:160], 32'd6);
        chk("t6_wg3", wg3[31:0], 32'd7);
        chk("t6_wd2", wd2[31:0], 32'd34);
        chk("t6_wd3", wd3[95:64], 32'd63);
        chk("t6_wd3_lo", wd3[31:0], 32'd61);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
